sdf_r2_butterfly: RTL and testbench

Radix-2 decimation-in-frequency butterfly with single-delay-feedback (SDF) control for one pipeline stage of the streaming FFT. Each stage contains one of these blocks, consuming serial complex samples from the previous stage and feeding the next stage.

- The block wraps the team's feedback delay line and drives it.
- In the first half-frame it parks samples in the delay line.
- In the second half-frame it forms sum and difference; sums are output, differences are parked in the delay line.
- Parked differences are output during the next frame's first half, tagged with the twiddle index the downstream twiddle multiplier needs.

---
 rtl/fft_pkg.sv | 42 ++++
 rtl/delay_line.sv | 51 +++++
 rtl/sdf_r2_butterfly.sv | 171 +++++++++++++++++
 tb/tb_sdf_r2_butterfly.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared types and arithmetic helpers for the streaming FFT stages.
//
// Contents:
//   FFT_DW     default component width of the FFT datapath
//   cplx_t     packed complex sample, {re, im}, each FFT_DW bits signed
//   sat_half() halve-with-rounding and saturate, used on every butterfly
//              output so that each stage's dynamic range stays at DW bits
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_DW = 12;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // Halve a (DW+1)-bit sum or difference with round-half-up, then clamp
    // to the signed DW-bit range. Only max - min can exceed the range after
    // halving, so the clamp is a corner case rather than the common path.
    // The value is carried in an int so that one function serves every
    // stage width; the caller truncates the result back to DW bits.
    function automatic int sat_half(input int v, input int dw);
        int rounded;
        int hi;
        int lo;
        rounded = (v + 1) >>> 1;
        hi      = (1 <<< (dw - 1)) - 1;
        lo      = -(1 <<< (dw - 1));
        if (rounded > hi) begin
            return hi;
        end
        if (rounded < lo) begin
            return lo;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/delay_line.sv
// ---------------------------------------------------------------------------
// delay_line
//
// Enable-gated shift register used as the feedback memory of an SDF stage.
// A word written on one enabled cycle appears at dout after LEN further
// enabled cycles, i.e. dout always shows the word written LEN strobes ago.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset, clears every stage to zero
//   en    shift enable; all stages hold while low
//   din   word entering the line (DW bits)
//   dout  word leaving the line (DW bits), combinational from the last stage
// ---------------------------------------------------------------------------
module delay_line #(
    parameter int DW  = 24,
    parameter int LEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] sr_q [LEN];
    logic [DW-1:0] sr_d [LEN];

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d[0] = din;
            for (int i = 1; i < LEN; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[LEN-1];

endmodule

// File: rtl/sdf_r2_butterfly.sv
// ---------------------------------------------------------------------------
// sdf_r2_butterfly
//
// Radix-2 decimation-in-frequency butterfly with single-delay-feedback
// control, one per stage of the streaming FFT. A frame is 2*LEN samples:
//   first half  : incoming samples are parked in the delay line, while the
//                 previous frame's parked differences are emitted with their
//                 twiddle index
//   second half : the parked sample and the incoming one form S(a+b), which
//                 is emitted, and S(a-b), which is parked for the next frame
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_in        input sample strobe (no backpressure)
//   x_re, x_im      input sample, DW bits signed each
//   y_valid         output strobe, one cycle after the producing valid_in
//   y_re, y_im      output sample, held between strobes
//   y_first         first output of a frame (sum, index 0)
//   y_last          last output of a frame (difference, index LEN-1)
//   tw_en           output is a difference and needs W^tw_idx downstream
//   tw_idx          twiddle index, KW bits
// ---------------------------------------------------------------------------
module sdf_r2_butterfly
    import fft_pkg::*;
#(
    parameter  int DW  = 12,
    parameter  int LEN = 8,
    localparam int KW  = (LEN > 1) ? $clog2(LEN) : 1,
    localparam int CW  = $clog2(2 * LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] x_re,
    input  logic signed [DW-1:0] x_im,
    output logic                 y_valid,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 y_first,
    output logic                 y_last,
    output logic                 tw_en,
    output logic [KW-1:0]        tw_idx
);

    logic [CW-1:0]        cnt_q,     cnt_d;
    logic                 primed_q,  primed_d;
    logic                 y_valid_q, y_valid_d;
    logic                 y_first_q, y_first_d;
    logic                 y_last_q,  y_last_d;
    logic                 tw_en_q,   tw_en_d;
    logic [KW-1:0]        tw_idx_q,  tw_idx_d;
    logic signed [DW-1:0] y_re_q,    y_re_d;
    logic signed [DW-1:0] y_im_q,    y_im_d;

    logic                 phase;
    logic [KW-1:0]        k;
    logic [2*DW-1:0]      dl_din;
    logic [2*DW-1:0]      dl_dout;
    logic signed [DW-1:0] a_re, a_im;
    logic signed [DW:0]   sum_re_w, sum_im_w, dif_re_w, dif_im_w;
    logic signed [DW-1:0] sum_re, sum_im, dif_re, dif_im;

    // Since 2*LEN is a power of two, the counter wraps naturally and its
    // MSB is the half-frame flag. Masking with LEN-1 yields the in-half
    // index and also covers LEN = 1, where the index is always zero.
    assign phase = cnt_q[CW-1];
    assign k     = KW'(cnt_q & CW'(LEN - 1));

    delay_line #(
        .DW  (2 * DW),
        .LEN (LEN)
    ) u_delay_line (
        .clk  (clk),
        .rst  (rst),
        .en   (valid_in),
        .din  (dl_din),
        .dout (dl_dout)
    );

    assign a_re = dl_dout[2*DW-1:DW];
    assign a_im = dl_dout[DW-1:0];

    // Butterfly arithmetic, one guard bit wide so that neither the sum nor
    // the difference can wrap before it is halved and saturated.
    always_comb begin
        sum_re_w = {a_re[DW-1], a_re} + {x_re[DW-1], x_re};
        sum_im_w = {a_im[DW-1], a_im} + {x_im[DW-1], x_im};
        dif_re_w = {a_re[DW-1], a_re} - {x_re[DW-1], x_re};
        dif_im_w = {a_im[DW-1], a_im} - {x_im[DW-1], x_im};
        sum_re   = DW'(sat_half(int'(sum_re_w), DW));
        sum_im   = DW'(sat_half(int'(sum_im_w), DW));
        dif_re   = DW'(sat_half(int'(dif_re_w), DW));
        dif_im   = DW'(sat_half(int'(dif_im_w), DW));
    end

    // Stage control and output selection. Strobe flags default low every
    // cycle; data registers and tw_idx hold until a strobe replaces them.
    // Outputs in the first half wait for primed, because until one full
    // half-frame has been parked the delay line holds no real differences.
    always_comb begin
        cnt_d     = cnt_q;
        primed_d  = primed_q;
        y_valid_d = 1'b0;
        y_first_d = 1'b0;
        y_last_d  = 1'b0;
        tw_en_d   = 1'b0;
        tw_idx_d  = tw_idx_q;
        y_re_d    = y_re_q;
        y_im_d    = y_im_q;
        dl_din    = {x_re, x_im};

        if (valid_in) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LEN - 1)) begin
                primed_d = 1'b1;
            end

            if (!phase) begin
                dl_din = {x_re, x_im};
                if (primed_q) begin
                    y_valid_d = 1'b1;
                    y_re_d    = a_re;
                    y_im_d    = a_im;
                    tw_en_d   = 1'b1;
                    tw_idx_d  = k;
                    y_last_d  = (k == KW'(LEN - 1));
                end
            end else begin
                dl_din    = {dif_re, dif_im};
                y_valid_d = 1'b1;
                y_re_d    = sum_re;
                y_im_d    = sum_im;
                y_first_d = (k == '0);
                tw_idx_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            primed_q  <= 1'b0;
            y_valid_q <= 1'b0;
            y_first_q <= 1'b0;
            y_last_q  <= 1'b0;
            tw_en_q   <= 1'b0;
            tw_idx_q  <= '0;
            y_re_q    <= '0;
            y_im_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            primed_q  <= primed_d;
            y_valid_q <= y_valid_d;
            y_first_q <= y_first_d;
            y_last_q  <= y_last_d;
            tw_en_q   <= tw_en_d;
            tw_idx_q  <= tw_idx_d;
            y_re_q    <= y_re_d;
            y_im_q    <= y_im_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_first = y_first_q;
    assign y_last  = y_last_q;
    assign tw_en   = tw_en_q;
    assign tw_idx  = tw_idx_q;
    assign y_re    = y_re_q;
    assign y_im    = y_im_q;

endmodule

// File: tb/tb_sdf_r2_butterfly.sv
// ---------------------------------------------------------------------------
// tb_sdf_r2_butterfly
//
// Self-checking bench for sdf_r2_butterfly with DW = 12, LEN = 4. A
// reference model keeps every sample accepted since reset in a queue and
// derives each expected output from the sample's position in its frame:
// second-half positions yield the scaled sum with the partner LEN samples
// earlier, first-half positions yield the scaled difference of the previous
// frame's pair at that index.
// ---------------------------------------------------------------------------
module tb_sdf_r2_butterfly;

    localparam int DW  = 12;
    localparam int LEN = 4;
    localparam int KW  = 2;
    localparam int FL  = 2 * LEN;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid_in;
    logic signed [DW-1:0] x_re;
    logic signed [DW-1:0] x_im;
    logic                 y_valid;
    logic signed [DW-1:0] y_re;
    logic signed [DW-1:0] y_im;
    logic                 y_first;
    logic                 y_last;
    logic                 tw_en;
    logic [KW-1:0]        tw_idx;

    int checks = 0;
    int errors = 0;

    int hist_re[$];
    int hist_im[$];
    int last_re;
    int last_im;

    always #5 clk = ~clk;

    sdf_r2_butterfly #(
        .DW  (DW),
        .LEN (LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .x_re     (x_re),
        .x_im     (x_im),
        .y_valid  (y_valid),
        .y_re     (y_re),
        .y_im     (y_im),
        .y_first  (y_first),
        .y_last   (y_last),
        .tw_en    (tw_en),
        .tw_idx   (tw_idx)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Halve with round-half-up (floor of (v+1)/2) and clamp to DW bits.
    function automatic int refScale(input int v);
        int t;
        int h;
        int lim;
        t = v + 1;
        h = t / 2;
        if (t < 0 && (t % 2) != 0) begin
            h = h - 1;
        end
        lim = 2 ** (DW - 1);
        if (h > lim - 1) h = lim - 1;
        if (h < -lim)    h = -lim;
        return h;
    endfunction

    // Drives one cycle (strobe or idle), then checks the registered outputs
    // 1 time unit after the edge against the model.
    task automatic applyStimulus(input bit v, input int re, input int im);
        int n, p, f;
        bit exp_v, exp_first, exp_last, exp_tw;
        int exp_re, exp_im, exp_idx;
        valid_in = v;
        x_re     = DW'(re);
        x_im     = DW'(im);
        @(posedge clk);
        #1;
        exp_v = 0; exp_first = 0; exp_last = 0; exp_tw = 0; exp_idx = 0;
        exp_re = last_re;
        exp_im = last_im;
        if (v) begin
            n = hist_re.size();
            hist_re.push_back(re);
            hist_im.push_back(im);
            p = n % FL;
            f = n / FL;
            if (p >= LEN) begin
                exp_v     = 1;
                exp_re    = refScale(hist_re[n-LEN] + re);
                exp_im    = refScale(hist_im[n-LEN] + im);
                exp_first = (p == LEN);
            end else if (f > 0) begin
                exp_v    = 1;
                exp_re   = refScale(hist_re[n-FL] - hist_re[n-LEN]);
                exp_im   = refScale(hist_im[n-FL] - hist_im[n-LEN]);
                exp_last = (p == LEN - 1);
                exp_tw   = 1;
                exp_idx  = p;
            end
        end
        valid_in = 1'b0;
        checkOutput("y_valid", int'(y_valid), int'(exp_v));
        checkOutput("y_first", int'(y_first), int'(exp_first));
        checkOutput("y_last",  int'(y_last),  int'(exp_last));
        checkOutput("tw_en",   int'(tw_en),   int'(exp_tw));
        checkOutput("y_re",    int'(y_re),    exp_re);
        checkOutput("y_im",    int'(y_im),    exp_im);
        if (exp_tw) begin
            checkOutput("tw_idx", int'(tw_idx), exp_idx);
        end
        last_re = exp_re;
        last_im = exp_im;
    endtask

    task automatic applyReset();
        rst      = 1'b1;
        valid_in = 1'b0;
        x_re     = '0;
        x_im     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_y_valid", int'(y_valid), 0);
        checkOutput("rst_y_first", int'(y_first), 0);
        checkOutput("rst_y_last",  int'(y_last),  0);
        checkOutput("rst_tw_en",   int'(tw_en),   0);
        checkOutput("rst_y_re",    int'(y_re),    0);
        checkOutput("rst_y_im",    int'(y_im),    0);
        checkOutput("rst_tw_idx",  int'(tw_idx),  0);
        rst = 1'b0;
        hist_re.delete();
        hist_im.delete();
        last_re = 0;
        last_im = 0;
    endtask

    // gap_mode 0: contiguous, 1: two idle cycles after every strobe,
    // 2: 0..3 random idle cycles after every strobe.
    task automatic sendSamples(input int re[FL], input int im[FL], input int count, input int gap_mode);
        int gaps;
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, re[i], im[i]);
            gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gaps; g++) begin
                applyStimulus(1'b0, 0, 0);
            end
        end
    endtask

    task automatic sendFrame(input int re[FL], input int im[FL], input int gap_mode);
        sendSamples(re, im, FL, gap_mode);
    endtask

    initial begin
        int zero[FL];
        int imp[FL];
        int ramp_re[FL];
        int ramp_im[FL];
        int r_re[FL];
        int r_im[FL];
        int t_re[FL];

        for (int i = 0; i < FL; i++) begin
            zero[i]    = 0;
            imp[i]     = 0;
            ramp_re[i] = i + 1;
            ramp_im[i] = -(i + 1);
        end
        imp[0] = 100;

        rst      = 1'b0;
        valid_in = 1'b0;
        x_re     = '0;
        x_im     = '0;
        last_re  = 0;
        last_im  = 0;

        $display("[TB] reset and impulse");
        applyReset();
        sendFrame(imp, zero, 0);
        sendFrame(zero, zero, 0);

        $display("[TB] rounding and clamp");
        applyReset();
        t_re = zero; t_re[0] = 2047;  t_re[LEN] = -2048;
        sendFrame(t_re, zero, 0);
        t_re = zero; t_re[0] = -2048; t_re[LEN] = -2048;
        sendFrame(t_re, zero, 0);
        t_re = zero; t_re[0] = 3;
        sendFrame(t_re, zero, 0);
        sendFrame(zero, zero, 0);

        $display("[TB] gapped input");
        applyReset();
        sendFrame(imp, zero, 1);
        sendFrame(zero, zero, 1);
        applyReset();
        sendFrame(imp, zero, 2);
        sendFrame(zero, zero, 2);

        $display("[TB] reset mid-frame");
        applyReset();
        sendSamples(imp, zero, 6, 0);
        applyReset();
        sendFrame(imp, zero, 0);
        sendFrame(zero, zero, 0);

        $display("[TB] complex ramp");
        applyReset();
        sendFrame(ramp_re, ramp_im, 0);
        sendFrame(zero, zero, 0);

        $display("[TB] random frames");
        applyReset();
        for (int fr = 0; fr < 8; fr++) begin
            for (int i = 0; i < FL; i++) begin
                r_re[i] = int'($urandom_range(0, 4095)) - 2048;
                r_im[i] = int'($urandom_range(0, 4095)) - 2048;
            end
            if (fr == 3) begin
                r_re[0] = 2047;  r_re[LEN] = -2048;
                r_im[1] = -2048; r_im[LEN+1] = 2047;
            end
            sendFrame(r_re, r_im, (fr % 2 == 1) ? 2 : 0);
        end
        sendFrame(zero, zero, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
